// File: rtl/line_unrng_if.sv
// Word-in / column-out bus for the line range unpacker.
// valid/ready: a word transfers on a cycle where i_dvld and o_rdy are both high; o_href marks a valid column.
interface line_unrng_if #(
  parameter int DBUF_DW   = 8,
  parameter int KRNV_SZ   = 6,
  parameter int ODATA_RNG = 2
);
  localparam int COL_W         = DBUF_DW * KRNV_SZ;
  localparam int WORD_W        = COL_W * ODATA_RNG;
  localparam int ODATA_RNG_WTH = $clog2(ODATA_RNG + 1);

  logic [WORD_W-1:0]        i_data;
  logic                     i_dvld;
  logic                     i_hstr;
  logic                     i_hend;
  logic                     i_vstr;
  logic                     i_vend;
  logic [ODATA_RNG_WTH-1:0] i_lst_num;
  logic                     o_rdy;
  logic [COL_W-1:0]         o_data;
  logic                     o_href;
  logic                     o_hstr;
  logic                     o_hend;
  logic                     o_vstr;
  logic                     o_vend;
  logic                     o_err;
  logic                     dbg_send;

  modport master (
    output i_data, i_dvld, i_hstr, i_hend, i_vstr, i_vend, i_lst_num,
    input  o_rdy, o_data, o_href, o_hstr, o_hend, o_vstr, o_vend, o_err, dbg_send
  );

  modport slave (
    input  i_data, i_dvld, i_hstr, i_hend, i_vstr, i_vend, i_lst_num,
    output o_rdy, o_data, o_href, o_hstr, o_hend, o_vstr, o_vend, o_err, dbg_send
  );
endinterface

// File: rtl/line_unrng.sv
// Parallel-to-serial column unpacker: one wide word of ODATA_RNG columns in,
// one column per cycle out with regenerated line/frame timing flags.
module line_unrng #(
  parameter int DBUF_DW   = 8,
  parameter int KRNV_SZ   = 6,
  parameter int ODATA_RNG = 2
) (
  input  logic         clk,
  input  logic         rst,
  line_unrng_if.slave  bus
);
  localparam int COL_W         = DBUF_DW * KRNV_SZ;
  localparam int WORD_W        = COL_W * ODATA_RNG;
  localparam int ODATA_RNG_WTH = $clog2(ODATA_RNG + 1);
  localparam int CW            = ODATA_RNG_WTH;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hend_q, hend_d;
  logic                vend_q, vend_d;

  logic [COL_W-1:0]    data_q, data_d;
  logic                href_q, href_d;
  logic                hstr_q, hstr_d;
  logic                ohend_q, ohend_d;
  logic                vstr_q, vstr_d;
  logic                ovend_q, ovend_d;
  logic                err_q, err_d;

  logic [CW-1:0]       lst_cnt;
  logic [CW-1:0]       nxt_beat;
  logic                last_beat;
  logic                rdy;
  logic                accept;

  // Only a line-end word may be short; out-of-range counts fall back to a full word.
  always_comb begin
    lst_cnt = CW'(ODATA_RNG);
    if (bus.i_hend && (bus.i_lst_num != '0) && (bus.i_lst_num <= CW'(ODATA_RNG)))
      lst_cnt = bus.i_lst_num;
  end

  assign last_beat = (beat_q == cnt_q - CW'(1));
  assign nxt_beat  = beat_q + CW'(1);
  assign rdy       = (state_q == IDLE) || last_beat;
  assign accept    = bus.i_dvld && rdy;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    hend_d  = hend_q;
    vend_d  = vend_q;
    data_d  = '0;
    href_d  = 1'b0;
    hstr_d  = 1'b0;
    ohend_d = 1'b0;
    vstr_d  = 1'b0;
    ovend_d = 1'b0;
    err_d   = bus.i_dvld && !rdy;

    // Beat 0 goes straight from the input; the rest of the word shifts down through hold_q.
    if (accept) begin
      state_d = SEND;
      beat_d  = '0;
      cnt_d   = lst_cnt;
      hold_d  = bus.i_data >> COL_W;
      hend_d  = bus.i_hend;
      vend_d  = bus.i_vend;
      data_d  = bus.i_data[COL_W-1:0];
      href_d  = 1'b1;
      hstr_d  = bus.i_hstr;
      vstr_d  = bus.i_vstr;
      ohend_d = bus.i_hend && (lst_cnt == CW'(1));
      ovend_d = bus.i_vend && (lst_cnt == CW'(1));
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SEND: begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = nxt_beat;
            hold_d  = hold_q >> COL_W;
            data_d  = hold_q[COL_W-1:0];
            href_d  = 1'b1;
            ohend_d = hend_q && (nxt_beat == cnt_q - CW'(1));
            ovend_d = vend_q && (nxt_beat == cnt_q - CW'(1));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      hend_q  <= 1'b0;
      vend_q  <= 1'b0;
      data_q  <= '0;
      href_q  <= 1'b0;
      hstr_q  <= 1'b0;
      ohend_q <= 1'b0;
      vstr_q  <= 1'b0;
      ovend_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      hend_q  <= hend_d;
      vend_q  <= vend_d;
      data_q  <= data_d;
      href_q  <= href_d;
      hstr_q  <= hstr_d;
      ohend_q <= ohend_d;
      vstr_q  <= vstr_d;
      ovend_q <= ovend_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_rdy    = rdy;
  assign bus.o_data   = data_q;
  assign bus.o_href   = href_q;
  assign bus.o_hstr   = hstr_q;
  assign bus.o_hend   = ohend_q;
  assign bus.o_vstr   = vstr_q;
  assign bus.o_vend   = ovend_q;
  assign bus.o_err    = err_q;
  assign bus.dbg_send = (state_q == SEND);
endmodule
